// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM receive and transmit paths.
// Frame-position masking, slot/bit decode and channel-index width.
package i2s_pkg;

  localparam int POSN_W = 8;

  typedef logic [POSN_W-1:0] posn_t;

  typedef struct packed {
    posn_t slot;
    posn_t k;
  } posn_dec_t;

  function automatic posn_t posn_mask(
    input posn_t p,
    input int    clocks
  );
    posn_t m;
    m = posn_t'(clocks - 1);
    return p & m;
  endfunction

  function automatic posn_dec_t posn_decode(
    input posn_t p,
    input int    slot_len
  );
    posn_dec_t d;
    d.slot = posn_t'(int'(p) / slot_len);
    d.k    = posn_t'(int'(p) % slot_len);
    return d;
  endfunction

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_word_fifo.sv
// Synchronous word FIFO with same-cycle push/pop and a held last word.
// Push is taken when not full or when a pop happens in the same cycle.
module i2s_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] head;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head     = mem_q[rd_q[AW-1:0]];
  assign pop_data = empty ? last_q : head;

  // next pointers and the word shown once the FIFO drains
  always_comb begin
    wr_d   = wr_q + PW'(do_push);
    rd_d   = rd_q + PW'(do_pop);
    last_d = last_q;
    if (do_pop) last_d = head;
  end

  // pointer and last-word registers
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      last_q <= last_d;
    end
  end

  // storage array, written only on an accepted push
  always_ff @(posedge ck) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_tdm_rx.sv
// Multi-lane I2S/TDM receiver feeding a valid/ready word stream.
// Define I2S_RX_SIGN_EXT_EN to sign-extend words to OUT_BITS.
module i2s_tdm_rx
  import i2s_pkg::*;
#(
  parameter int BITS     = 24,
  parameter int CLOCKS   = 64,
  parameter int CHANNELS = 2,
  parameter int LANES    = 1,
  parameter int DELAY    = 1,
  parameter int OUT_BITS = 32,
  parameter int DEPTH    = 8,
  localparam int CW      = chan_w(LANES * CHANNELS)
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                sample,
  input  logic [POSN_W-1:0]   frame_posn,
  input  logic [LANES-1:0]    sd,
  output logic [OUT_BITS-1:0] out_data,
  output logic [CW-1:0]       out_chan,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  input  logic                clr_overrun
);

  localparam int SLOT   = CLOCKS / CHANNELS;
  localparam int LAST_K = DELAY + BITS - 1;
  localparam int FW     = CW + OUT_BITS;

  posn_t     posn;
  posn_dec_t dec;
  logic      capture;

  logic             synced_q, synced_d;
  logic [BITS-1:0]  shift_q [LANES];
  logic [BITS-1:0]  shift_d [LANES];
  logic [LANES-1:0] pend_q, pend_d;
  posn_t            pslot_q, pslot_d;
  logic             ovr_q, ovr_d;

  logic            push;
  logic            found;
  int              sel;
  logic [BITS-1:0] word;
  posn_t           wslot;
  logic [CW-1:0]   chan;
  logic [FW-1:0]   push_word;
  logic [FW-1:0]   pop_word;
  logic            full;
  logic            empty;
  logic            pop;

  function automatic logic [OUT_BITS-1:0] fmt(
    input logic [BITS-1:0] w
  );
    logic [OUT_BITS-1:0] r;
    r = '0;
    r[BITS-1:0] = w;
`ifdef I2S_RX_SIGN_EXT_EN
    for (int i = BITS; i < OUT_BITS; i++)
      r[i] = w[BITS-1];
`endif
    return r;
  endfunction

  assign posn = posn_mask(frame_posn, CLOCKS);
  assign dec  = posn_decode(posn, SLOT);

  assign capture = sample &&
                   (synced_q || posn == '0) &&
                   (dec.k == posn_t'(LAST_K));

  // frame sync and per-lane shift registers
  always_comb begin
    synced_d = synced_q;
    if (sample && posn == '0) synced_d = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      shift_d[l] = shift_q[l];
      if (sample)
        shift_d[l] = {shift_q[l][BITS-2:0], sd[l]};
    end
  end

  // lane serialiser: lane 0 pushes at capture, the rest drain after
  always_comb begin
    pend_d  = pend_q;
    pslot_d = pslot_q;
    push    = 1'b0;
    found   = 1'b0;
    sel     = 0;
    word    = shift_q[0];
    wslot   = pslot_q;
    if (capture) begin
      push      = 1'b1;
      pend_d    = '1;
      pend_d[0] = 1'b0;
      pslot_d   = dec.slot;
      word      = shift_d[0];
      wslot     = dec.slot;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (pend_q[l] && !found) begin
          found = 1'b1;
          sel   = l;
        end
      end
      if (found) begin
        push        = 1'b1;
        pend_d[sel] = 1'b0;
        word        = shift_q[sel];
      end
    end
    chan      = CW'(sel * CHANNELS + int'(wslot));
    push_word = {chan, fmt(word)};
  end

  assign pop = out_ready && !empty;

  // sticky overrun; a clear beats a same-cycle drop
  always_comb begin
    ovr_d = ovr_q;
    if (push && full && !pop) ovr_d = 1'b1;
    if (clr_overrun)          ovr_d = 1'b0;
  end

  // receiver state registers
  always_ff @(posedge ck) begin
    if (rst) begin
      synced_q <= 1'b0;
      pend_q   <= '0;
      pslot_q  <= '0;
      ovr_q    <= 1'b0;
      for (int l = 0; l < LANES; l++)
        shift_q[l] <= '0;
    end else begin
      synced_q <= synced_d;
      pend_q   <= pend_d;
      pslot_q  <= pslot_d;
      ovr_q    <= ovr_d;
      for (int l = 0; l < LANES; l++)
        shift_q[l] <= shift_d[l];
    end
  end

  i2s_word_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck        (ck),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .full      (full),
    .pop       (out_ready),
    .pop_data  (pop_word),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign out_data  = pop_word[OUT_BITS-1:0];
  assign out_chan  = pop_word[FW-1:OUT_BITS];
  assign overrun   = ovr_q;

endmodule
